// File: rtl/spi_slv_pkg.sv
// Shared types and constants for the parametrised SPI slave front-end:
// FSM state encoding, command encodings and frame-width helper.
package spi_slv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHK_CMD = 3'd1,
    ST_RX      = 3'd2,
    ST_WAIT_TX = 3'd3,
    ST_TX      = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Frame width: 2-bit command followed by the payload.
  function automatic int rx_width(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/spi_slv_piso.sv
// TX serialiser for the SPI slave: loads a RAM read word and shifts it out
// MSB-first, one bit per clock. The first bit is driven on the load edge.
// With SPI_SLV_PARITY_EN defined an odd-parity bit follows the data.
module spi_slv_piso #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_bit,
  output logic              o_done
);

`ifdef SPI_SLV_PARITY_EN
  localparam int TX_BITS = DATA_W + 1;
`else
  localparam int TX_BITS = DATA_W;
`endif
  localparam int               CNT_W    = $clog2(TX_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TX_BITS);

  logic [TX_BITS-1:0] w_word;
  logic [TX_BITS-1:0] r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_bit;

`ifdef SPI_SLV_PARITY_EN
  assign w_word = {i_data, ~^i_data};
`else
  assign w_word = i_data;
`endif

  // Load/shift engine; r_cnt counts bits already driven, 0 means inactive.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_bit   <= 1'b0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_bit   <= 1'b0;
    end else if (i_load) begin
      r_bit   <= w_word[TX_BITS-1];
      r_shift <= {w_word[TX_BITS-2:0], 1'b0};
      r_cnt   <= CNT_W'(1);
    end else if (r_cnt != '0) begin
      if (r_cnt == LAST_CNT) begin
        r_bit <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_bit   <= r_shift[TX_BITS-1];
        r_shift <= {r_shift[TX_BITS-2:0], 1'b0};
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_bit  = r_bit;
  assign o_done = (r_cnt == LAST_CNT);

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end for the single-port RAM subsystem.
// Deserialises {cmd, payload} frames MSB-first, strobes them to the RAM
// controller, and serialises RAM read data for RD_DATA after RD_ADDR.
// Optional feature macro: SPI_SLV_PARITY_EN (odd parity on RX and TX).
module spi_slave_param
  import spi_slv_pkg::*;
#(
  parameter int  DATA_W = 8,
  localparam int RX_W   = rx_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ss_n,
  input  logic              i_mosi,
  input  logic              i_tx_valid,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_miso,
  output logic              o_rx_valid,
  output logic [RX_W-1:0]   o_rx_data,
  output logic              o_busy,
  output logic              o_rx_err
);

`ifdef SPI_SLV_PARITY_EN
  localparam int FRM_W = RX_W + 1;
`else
  localparam int FRM_W = RX_W;
`endif
  localparam int               CNT_W    = $clog2(FRM_W + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRM_W);

  state_t            r_state;
  state_t            w_next;
  logic [FRM_W-1:0]  r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rd_pend;
  logic [RX_W-1:0]   r_rx_data;
  logic              r_rx_valid;

  logic [RX_W-1:0]   w_rx_frame;
  logic [1:0]        w_cmd;
  logic              w_frame_done;
  logic              w_par_ok;
  logic              w_frame_ok;
  logic              w_tx_load;
  logic              w_tx_done;
  logic              w_tx_bit;

  assign w_rx_frame   = r_shift[FRM_W-1 -: RX_W];
  assign w_cmd        = w_rx_frame[RX_W-1 -: 2];
  assign w_frame_done = (r_state == ST_RX) && (r_cnt == FULL_CNT) && !i_ss_n;
  assign w_frame_ok   = w_frame_done && w_par_ok;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; ss_n high in any active state aborts to IDLE.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next    = r_state;
    w_tx_load = 1'b0;
    if (r_state != ST_IDLE && i_ss_n) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (!i_ss_n) w_next = ST_CHK_CMD;
        ST_CHK_CMD: w_next = ST_RX;
        ST_RX: begin
          if (w_frame_done) begin
            if (w_par_ok && w_cmd == CMD_RD_DATA && r_rd_pend) w_next = ST_WAIT_TX;
            else                                               w_next = ST_DONE;
          end
        end
        ST_WAIT_TX: begin
          if (i_tx_valid) begin
            w_next    = ST_TX;
            w_tx_load = 1'b1;
          end
        end
        ST_TX:      if (w_tx_done) w_next = ST_DONE;
        ST_DONE:    w_next = ST_DONE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  // Deserialiser: shift in MOSI during CHK_CMD/RX; counter cleared on ss_n high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_ss_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_CHK_CMD) begin
      r_shift <= {r_shift[FRM_W-2:0], i_mosi};
      r_cnt   <= CNT_W'(1);
    end else if (r_state == ST_RX) begin
      if (r_cnt == FULL_CNT) begin
        r_cnt <= '0;
      end else begin
        r_shift <= {r_shift[FRM_W-2:0], i_mosi};
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Frame hand-off to the RAM controller: data held until the next good frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= w_frame_ok;
      if (w_frame_ok) r_rx_data <= w_rx_frame;
    end
  end

  // Read pairing: RD_ADDR arms a pending read, RD_DATA consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
    end else if (w_frame_ok) begin
      if (w_cmd == CMD_RD_ADDR)      r_rd_pend <= 1'b1;
      else if (w_cmd == CMD_RD_DATA) r_rd_pend <= 1'b0;
    end
  end

`ifdef SPI_SLV_PARITY_EN
  logic r_rx_err;

  assign w_par_ok = ^r_shift;

  // Parity error strobe, raised where rx_valid would otherwise have risen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_err <= 1'b0;
    else        r_rx_err <= w_frame_done && !w_par_ok;
  end

  assign o_rx_err = r_rx_err;
`else
  assign w_par_ok = 1'b1;
  assign o_rx_err = 1'b0;
`endif

  spi_slv_piso #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_tx_load),
    .i_clear (i_ss_n),
    .i_data  (i_tx_data),
    .o_bit   (w_tx_bit),
    .o_done  (w_tx_done)
  );

  assign o_miso     = w_tx_bit;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_data;
  assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench for spi_slave_param (DATA_W=8). Received frames are
// checked through a scoreboard queue; MISO and status inline per scenario.
// Honours SPI_SLV_PARITY_EN when the design is built with it.
module tb_spi_slave_param;

  localparam int DATA_W = 8;
  localparam int RX_W   = DATA_W + 2;
`ifdef SPI_SLV_PARITY_EN
  localparam int FRM_LEN = RX_W + 1;
  localparam int TX_LEN  = DATA_W + 1;
`else
  localparam int FRM_LEN = RX_W;
  localparam int TX_LEN  = DATA_W;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ss_n;
  logic              mosi;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              miso;
  logic              rx_valid;
  logic [RX_W-1:0]   rx_data;
  logic              busy;
  logic              rx_err;

  typedef struct packed {
    logic            err;
    logic            vld;
    logic [RX_W-1:0] data;
  } ev_t;

  ev_t             exp_q[$];
  int              n_checks = 0;
  int              n_pass   = 0;
  logic [RX_W-1:0] last_rx  = '0;

  always #5 clk = ~clk;

  spi_slave_param #(
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ss_n     (ss_n),
    .i_mosi     (mosi),
    .i_tx_valid (tx_valid),
    .i_tx_data  (tx_data),
    .o_miso     (miso),
    .o_rx_valid (rx_valid),
    .o_rx_data  (rx_data),
    .o_busy     (busy),
    .o_rx_err   (rx_err)
  );

  // Scoreboard: every rx_valid / rx_err cycle must match the next expected event.
  always @(negedge clk) begin
    ev_t obs;
    ev_t exp_ev;
    if (rst_n === 1'b1 && (rx_valid === 1'b1 || rx_err === 1'b1)) begin
      obs.err  = rx_err;
      obs.vld  = rx_valid;
      obs.data = (rx_valid === 1'b1) ? rx_data : '0;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rx_event: got err=%0b vld=%0b data=%h, required no event", obs.err, obs.vld, obs.data);
      end else begin
        exp_ev = exp_q.pop_front();
        if (obs !== exp_ev)
          $display("FAIL rx_event: got err=%0b vld=%0b data=%h, required err=%0b vld=%0b data=%h",
                   obs.err, obs.vld, obs.data, exp_ev.err, exp_ev.vld, exp_ev.data);
        else n_pass++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) $display("FAIL %s: got %0h, required %0h", name, got, req);
    else n_pass++;
  endtask

  // Send one frame starting from an idle slave; return at the negedge after the
  // rx_valid edge with ss_n still low when keep_ss is set.
  task automatic send_frame(input logic [1:0] cmd, input logic [DATA_W-1:0] pl,
                            input bit bad_par, input bit keep_ss);
    logic [FRM_LEN-1:0] f;
    ev_t                e;
    logic               miso_bad;
`ifdef SPI_SLV_PARITY_EN
    f = {cmd, pl, (~^{cmd, pl}) ^ bad_par};
`else
    f = {cmd, pl};
`endif
    e.err  = bad_par;
    e.vld  = !bad_par;
    e.data = bad_par ? '0 : {cmd, pl};
    exp_q.push_back(e);
    miso_bad = 1'b0;
    @(negedge clk);
    ss_n = 1'b0;
    for (int i = FRM_LEN - 1; i >= 0; i--) begin
      @(negedge clk);
      if (miso !== 1'b0) miso_bad = 1'b1;
      mosi = f[i];
    end
    @(negedge clk);
    chk("rx_valid_early", {31'd0, rx_valid}, 32'd0);
    @(negedge clk);
    chk("frame_strobe", {30'd0, rx_err, rx_valid}, {30'd0, bad_par, !bad_par});
    chk("miso_during_rx", {31'd0, miso_bad}, 32'd0);
    if (!bad_par) last_rx = {cmd, pl};
    mosi = 1'b0;
    if (!keep_ss) ss_n = 1'b1;
  endtask

  // Slave must be in DONE (not WAIT_TX): tx_valid ignored, miso stays 0.
  task automatic check_no_tx(input string name);
    logic bad;
    bad = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (miso !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    chk(name, {31'd0, bad}, 32'd0);
    ss_n = 1'b1;
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  // Slave is in WAIT_TX: supply read data three cycles later and check MISO.
  task automatic tx_read(input logic [DATA_W-1:0] d);
    logic [TX_LEN-1:0] w;
    logic              exp_bit[$];
    logic              eb;
`ifdef SPI_SLV_PARITY_EN
    w = {d, ~^d};
`else
    w = d;
`endif
    for (int i = TX_LEN - 1; i >= 0; i--) exp_bit.push_back(w[i]);
    chk("wait_tx_state", {30'd0, busy, miso}, 32'd2);
    @(negedge clk);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    for (int k = 0; k < TX_LEN; k++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      eb = exp_bit.pop_front();
      chk($sformatf("miso_bit%0d", k), {31'd0, miso}, {31'd0, eb});
    end
    @(negedge clk);
    chk("tx_end_done", {30'd0, busy, miso}, 32'd2);
    ss_n = 1'b1;
    @(negedge clk);
    chk("tx_end_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    #12;
    chk("reset_outputs", {28'd0, miso, rx_valid, rx_err, busy}, 32'd0);
    chk("reset_rx_data", {22'd0, rx_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wr_addr();
    send_frame(2'b00, 8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    chk("wr_addr_rx_data_held", {22'd0, rx_data}, 32'h0A5);
  endtask

  task automatic test_orphan_rd();
    send_frame(2'b11, 8'h5A, 1'b0, 1'b1);
    check_no_tx("orphan_rd_no_tx");
  endtask

  task automatic test_read_pair();
    send_frame(2'b10, 8'h03, 1'b0, 1'b0);
    send_frame(2'b11, 8'h00, 1'b0, 1'b1);
    tx_read(8'hC3);
    send_frame(2'b11, 8'h00, 1'b0, 1'b1);
    check_no_tx("rd_pend_cleared");
  endtask

  task automatic test_abort();
    @(negedge clk);
    ss_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mosi = i[0];
    end
    @(negedge clk);
    ss_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_rx_data_held", {22'd0, rx_data}, {22'd0, last_rx});
    send_frame(2'b01, 8'hF0, 1'b0, 1'b0);
  endtask

  task automatic test_abort_last_bit();
    @(negedge clk);
    ss_n = 1'b0;
    for (int i = 0; i < FRM_LEN - 1; i++) begin
      @(negedge clk);
      mosi = i[0];
    end
    @(negedge clk);
    mosi = 1'b1;
    ss_n = 1'b1;
    @(negedge clk);
    chk("abort_last_bit_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("abort_last_bit_no_valid", {31'd0, rx_valid}, 32'd0);
  endtask

  task automatic test_abort_tx_valid();
    logic bad;
    send_frame(2'b10, 8'h77, 1'b0, 1'b0);
    send_frame(2'b11, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    ss_n     = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("abort_tx_valid_state", {30'd0, busy, miso}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (miso !== 1'b0) bad = 1'b1;
    end
    chk("abort_tx_valid_miso", {31'd0, bad}, 32'd0);
  endtask

  task automatic test_reset_mid_tx();
    send_frame(2'b10, 8'h5A, 1'b0, 1'b0);
    send_frame(2'b11, 8'h11, 1'b0, 1'b1);
    tx_valid = 1'b1;
    tx_data  = 8'hF0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    chk("mid_tx_bit4", {31'd0, miso}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_tx_reset_outputs", {29'd0, miso, busy, rx_valid}, 32'd0);
    chk("mid_tx_reset_rx_data", {22'd0, rx_data}, 32'd0);
    last_rx = '0;
    ss_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(2'b11, 8'h22, 1'b0, 1'b1);
    check_no_tx("mid_tx_rd_pend_cleared");
  endtask

  task automatic test_back_to_back();
    send_frame(2'b00, 8'h00, 1'b0, 1'b0);
    send_frame(2'b01, 8'hFF, 1'b0, 1'b0);
    send_frame(2'b00, 8'h81, 1'b0, 1'b0);
  endtask

`ifdef SPI_SLV_PARITY_EN
  task automatic test_parity();
    send_frame(2'b01, 8'h55, 1'b1, 1'b0);
    @(negedge clk);
    chk("parity_err_rx_data_held", {22'd0, rx_data}, {22'd0, last_rx});
    send_frame(2'b01, 8'h55, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_wr_addr();
    test_orphan_rd();
    test_read_pair();
    test_abort();
    test_abort_last_bit();
    test_abort_tx_valid();
    test_reset_mid_tx();
    test_back_to_back();
`ifdef SPI_SLV_PARITY_EN
    test_parity();
`endif
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
